// File: rtl/adc_spi_reader.sv
// adc_spi_reader: free-running SPI master sampling an AD7476-style ADC every SAMPLE_DIV clocks.
// Define ADC_SPI_SIGNED_EN to present samples as two's complement instead of offset-binary.
module adc_spi_reader #(
    parameter int CLK_DIV    = 2,
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12,
    parameter int SAMPLE_DIV = 100
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 en,
    output logic                 ss,
    output logic                 sck,
    output logic                 mosi,
    input  logic                 miso,
    output logic [DATA_BITS-1:0] sample,
    output logic                 valid,
    output logic                 overrun
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(2 * FRAME_BITS);
    localparam int CW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(2 * FRAME_BITS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);
`ifdef ADC_SPI_SIGNED_EN
    localparam logic [DATA_BITS-1:0] FLIP = DATA_BITS'(1) << (DATA_BITS - 1);
`else
    localparam logic [DATA_BITS-1:0] FLIP = '0;
`endif

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
    state_t state, nxt;
    logic [DW-1:0] div;
    logic [HW-1:0] h;
    logic [CW-1:0] cnt;
    logic [FRAME_BITS-1:0] sr;
    logic run, tick, div_end, rise;

    // run delays the counter by one cycle so the first tick lands SAMPLE_DIV edges after en is seen
    assign tick    = en & run & (cnt == CNT_LAST);
    assign div_end = div == DIV_LAST;
    assign rise    = (state == SHIFT) & div_end & ~h[0];

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = tick ? SETUP : IDLE;
            SETUP:   nxt = div_end ? SHIFT : SETUP;
            SHIFT:   nxt = (div_end && h == H_LAST) ? HOLD : SHIFT;
            HOLD:    nxt = div_end ? IDLE : HOLD;
            default: nxt = IDLE;
        endcase
    end

    // h counts SCK half-periods within SHIFT: even halves low, odd halves high
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            run     <= 1'b0;
            cnt     <= '0;
            div     <= '0;
            h       <= '0;
            sr      <= '0;
            sample  <= '0;
            overrun <= 1'b0;
        end else begin
            run     <= en;
            cnt     <= (!en || !run || cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            div     <= (state == IDLE || div_end) ? '0 : div + DW'(1);
            h       <= state != SHIFT ? '0 : div_end ? h + HW'(1) : h;
            overrun <= en & (overrun | (tick & (state != IDLE)));
            if (rise) sr <= (sr << 1) | FRAME_BITS'(miso);
            if (state == SHIFT && nxt == HOLD) sample <= sr[DATA_BITS-1:0] ^ FLIP;
        end
    end

    always_comb begin
        ss    = (state == IDLE) || (state == HOLD);
        sck   = state == SHIFT ? h[0] : 1'b1;
        valid = (state == HOLD) && (div == '0);
        mosi  = 1'b0;
    end
endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: two readers (default timing, and CLK_DIV=1/SAMPLE_DIV=20 for overrun) against a timeline model.
module tb_adc_spi_reader;
    localparam int F  = 16;
    localparam int NW = 256;
`ifdef ADC_SPI_SIGNED_EN
    localparam logic [11:0] FIRST = 12'h2BC;
`else
    localparam logic [11:0] FIRST = 12'hABC;
`endif

    logic CLK = 1'b0, RST_N, en;
    logic [1:0] d_ss, d_sck, d_mosi, d_valid, d_ovr, d_miso = 2'b00;
    logic [11:0] d_smp [2];
    always #5 CLK = ~CLK;

    adc_spi_reader u_a (
        .CLK(CLK), .RST_N(RST_N), .en(en), .ss(d_ss[0]), .sck(d_sck[0]), .mosi(d_mosi[0]),
        .miso(d_miso[0]), .sample(d_smp[0]), .valid(d_valid[0]), .overrun(d_ovr[0])
    );
    adc_spi_reader #(.CLK_DIV(1), .SAMPLE_DIV(20)) u_b (
        .CLK(CLK), .RST_N(RST_N), .en(en), .ss(d_ss[1]), .sck(d_sck[1]), .mosi(d_mosi[1]),
        .miso(d_miso[1]), .sample(d_smp[1]), .valid(d_valid[1]), .overrun(d_ovr[1])
    );

    int tests = 0, fails = 0, cyc = 0;
    int dv [2] = '{2, 1};
    int sv [2] = '{100, 20};
    logic [15:0] words [2][NW];
    logic [15:0] fixed [6] = '{16'h0ABC, 16'h0000, 16'h0FFF, 16'h0800, 16'h07FF, 16'h0555};

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s[%0d] cycle %0d: got %0h, want %0h", nm, i, cyc, act, exp);
        end
    endtask

    function automatic logic [11:0] exp_of(input logic [15:0] w);
`ifdef ADC_SPI_SIGNED_EN
        return w[11:0] ^ 12'h800;
`else
        return w[11:0];
`endif
    endfunction

    // ADC: shifts the next word out MSB-first, one bit per SCK falling edge while selected
    int af [2] = '{-1, -1};
    int bc [2] = '{0, 0};
    logic [1:0] pss = 2'b11, psck = 2'b11;
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (d_ss[i] === 1'b0 && pss[i] === 1'b1) begin
                af[i]++;
                bc[i] = 0;
            end
            if (d_ss[i] !== 1'b0) d_miso[i] = 1'b0;
            else if (psck[i] === 1'b1 && d_sck[i] === 1'b0 && bc[i] < F) begin
                d_miso[i] = words[i][af[i] % NW][F - 1 - bc[i]];
                bc[i]++;
            end
        end
        pss  = d_ss;
        psck = d_sck;
    end

    // Model: each frame is a fixed timeline measured from the edge that accepted its tick
    int enrun [2] = '{0, 0};
    int start [2] = '{-1, -1};
    int mf [2] = '{-1, -1};
    logic [1:0] e_ss = 2'b11, e_sck = 2'b11, e_v = 2'b00, e_ovr = 2'b00;
    logic [11:0] e_smp [2] = '{12'h0, 12'h0};
    always @(posedge CLK) begin : model
        int t, ln, vt;
        logic tk, busy;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            ln = (2 + 2 * F) * dv[i];
            vt = (1 + 2 * F) * dv[i];
            if (!RST_N) begin
                enrun[i] = 0;
                start[i] = -1;
                e_ovr[i] = 1'b0;
                e_smp[i] = '0;
            end else begin
                t    = cyc - start[i];
                busy = start[i] >= 0 && t >= 1 && t <= ln;
                tk   = en && enrun[i] > 0 && enrun[i] % sv[i] == 0;
                enrun[i] = en ? enrun[i] + 1 : 0;
                e_ovr[i] = en && (e_ovr[i] || (tk && busy));
                if (tk && !busy) begin
                    start[i] = cyc;
                    mf[i]++;
                end
                if (start[i] >= 0 && cyc - start[i] == vt) e_smp[i] = exp_of(words[i][mf[i] % NW]);
            end
            t = cyc - start[i];
            if (start[i] < 0 || t >= ln) begin
                e_ss[i]  = 1'b1;
                e_sck[i] = 1'b1;
                e_v[i]   = 1'b0;
            end else begin
                e_ss[i]  = t >= vt;
                e_sck[i] = (t >= dv[i] && t < vt) ? (((t - dv[i]) / dv[i]) % 2 == 1) : 1'b1;
                e_v[i]   = t == vt;
            end
        end
    end

    always @(negedge CLK) begin
        if (cyc > 0) begin
            for (int i = 0; i < 2; i++) begin
                chk("ss", i, d_ss[i], e_ss[i]);
                chk("sck", i, d_sck[i], e_sck[i]);
                chk("mosi", i, d_mosi[i], 0);
                chk("valid", i, d_valid[i], e_v[i]);
                chk("overrun", i, d_ovr[i], e_ovr[i]);
                chk("sample", i, d_smp[i], e_smp[i]);
            end
        end
    end

    int vlast [2] = '{0, 0};
    int vprev [2] = '{0, 0};
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (d_valid[i] === 1'b1) begin
                vprev[i] = vlast[i];
                vlast[i] = cyc;
            end
        end
    end

    task automatic wait_ss_fall(input int bound);
        for (int n = 0; n < bound && d_ss[0] !== 1'b0; n++) @(negedge CLK);
    endtask

    initial begin
        int e0, rises, cnt, lv, pv, lows;
        logic ps;
        RST_N = 1'b0;
        en    = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < NW; k++) words[i][k] = k < 6 ? fixed[k] : 16'($urandom);
        repeat (3) @(negedge CLK);
        chk("rst_ss", 2, d_ss, 2'b11);
        chk("rst_sck", 2, d_sck, 2'b11);
        chk("rst_valid", 2, d_valid, 2'b00);
        chk("rst_overrun", 2, d_ovr, 2'b00);
        chk("rst_sample", 0, d_smp[0], 0);
        RST_N = 1'b1;
        @(negedge CLK);
        en = 1'b1;
        e0 = cyc + 1;
        for (int n = 0; n < 200 && d_ss[0] !== 1'b0; n++) @(negedge CLK);
        chk("first_ss_fall", 0, cyc - e0, 100);
        rises = 0;
        ps = d_sck[0];
        for (int n = 0; n < 200 && d_valid[0] !== 1'b1; n++) begin
            @(negedge CLK);
            if (ps === 1'b0 && d_sck[0] === 1'b1) rises++;
            ps = d_sck[0];
        end
        chk("sck_rises", 0, rises, 16);
        chk("valid_time", 0, cyc - e0, 166);
        chk("first_sample", 0, d_smp[0], FIRST);
        chk("b_overrun", 1, d_ovr[1], 1);
        chk("b_period", 1, vlast[1] - vprev[1], 40);
        cnt = 0;
        lv  = 0;
        pv  = 0;
        repeat (500) begin
            @(negedge CLK);
            if (d_valid[0] === 1'b1) begin
                cnt++;
                pv = lv;
                lv = cyc;
            end
        end
        chk("a_valid_count", 0, cnt, 5);
        chk("a_period", 0, lv - pv, 100);
        chk("a_no_overrun", 0, d_ovr[0], 0);
        en = 1'b0;
        @(negedge CLK);
        chk("ovr_clear", 1, d_ovr[1], 0);
        en = 1'b1;
        wait_ss_fall(300);
        repeat (10) @(negedge CLK);
        en = 1'b0;
        for (int n = 0; n < 100 && d_valid[0] !== 1'b1; n++) @(negedge CLK);
        chk("midframe_valid", 0, d_valid[0], 1);
        lows = 0;
        repeat (300) begin
            @(negedge CLK);
            if (d_ss[0] !== 1'b1) lows++;
        end
        chk("idle_while_off", 0, lows, 0);
        en = 1'b1;
        wait_ss_fall(300);
        rises = 0;
        ps = d_sck[0];
        for (int n = 0; n < 100 && rises < 8; n++) begin
            @(negedge CLK);
            if (ps === 1'b0 && d_sck[0] === 1'b1) rises++;
            ps = d_sck[0];
        end
        RST_N = 1'b0;
        @(negedge CLK);
        chk("rst_mid_ss", 0, d_ss[0], 1);
        chk("rst_mid_sck", 0, d_sck[0], 1);
        chk("rst_mid_valid", 0, d_valid[0], 0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int n = 0; n < 300 && d_valid[0] !== 1'b1; n++) @(negedge CLK);
        chk("clean_frame_valid", 0, d_valid[0], 1);
        repeat (3000) begin
            @(negedge CLK);
            if ($urandom_range(0, 149) == 0) en = ~en;
            RST_N = $urandom_range(0, 799) != 0;
        end
        RST_N = 1'b1;
        @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
